tt_um_prog_counter: RTL and testbench

Parametrised successor to the team's free-running 4-bit counter. Adds modulo-N wrap, up/down direction, saturate mode, synchronous clear and load, and a programmable prescaler. Outputs are a terminal-count pulse, a compare match and a sticky overflow flag. Sits behind the Tiny Tapeout top-level pin wrapper: switches/bidirectionals drive control, and count/flags drive the 7-segment and outputs.

---
 rtl/tt_counter_pkg.sv | 19 +
 rtl/tt_prescaler.sv | 26 ++
 rtl/tt_um_prog_counter.sv | 88 ++++++++
 tb/tb_tt_um_prog_counter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/tt_counter_pkg.sv
// Shared definitions for the programmable counter family.
package tt_counter_pkg;

  // Count direction encodings as seen on the dir pin
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Boundary behaviour: wrap modulo MODULO or hold at the edge
  typedef enum logic { WRAP = 1'b0, SAT = 1'b1 } mode_e;

  // Ceiling log2 usable in parameter expressions
  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/tt_prescaler.sv
// Programmable divider: tick every div+1 enabled cycles, phase frozen while en=0.
module tt_prescaler #(
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               restart,
  input  logic               en,
  input  logic [PRESC_W-1:0] div,
  output logic               tick
);
  import tt_counter_pkg::*;

  logic [PRESC_W-1:0] cnt;

  // >= so that shrinking div below the running count ticks immediately
  assign tick = en && (cnt >= div);

  // Phase counter; restart realigns it with a clear/load of the count
  always_ff @(posedge clk) begin
    if (reset || restart) cnt <= '0;
    else if (tick)        cnt <= '0;
    else if (en)          cnt <= cnt + PRESC_W'(1);
  end

endmodule

// File: rtl/tt_um_prog_counter.sv
// Modulo-N up/down counter with saturate mode, prescaler and status flags.
module tt_um_prog_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULO  = 16,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               clear,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic               dir,
  input  logic               sat,
  input  logic [PRESC_W-1:0] presc_div,
  input  logic [WIDTH-1:0]   cmp_val,
  input  logic               ovf_clr,
  output logic [WIDTH-1:0]   count,
  output logic               tc,
  output logic               cmp_match,
  output logic               ovf_sticky
);
  import tt_counter_pkg::*;

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULO - 1);

  logic             tick;
  logic             presc_restart;
  logic             bnd;
  logic [WIDTH-1:0] count_nxt;
  mode_e            mode;

  assign presc_restart = clear | load;
  assign mode          = sat ? SAT : WRAP;

  tt_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk     (clk),
    .reset   (reset),
    .restart (presc_restart),
    .en      (en),
    .div     (presc_div),
    .tick    (tick)
  );

  // Next count and boundary detect; clear beats load beats step
  always_comb begin
    count_nxt = count;
    bnd       = 1'b0;
    if (clear) begin
      count_nxt = '0;
    end else if (load) begin
      count_nxt = (load_val > MAX) ? MAX : load_val;
    end else if (tick) begin
      if (dir == DIR_UP) begin
        if (count == MAX) begin
          bnd       = 1'b1;
          count_nxt = (mode == SAT) ? MAX : '0;
        end else begin
          count_nxt = count + WIDTH'(1);
        end
      end else begin
        if (count == '0) begin
          bnd       = 1'b1;
          count_nxt = (mode == SAT) ? '0 : MAX;
        end else begin
          count_nxt = count - WIDTH'(1);
        end
      end
    end
  end

  // Registered count and flags; match is taken from count_nxt to stay aligned
  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      tc         <= 1'b0;
      cmp_match  <= (cmp_val == '0);
      ovf_sticky <= 1'b0;
    end else begin
      count     <= count_nxt;
      tc        <= bnd;
      cmp_match <= (count_nxt == cmp_val);
      if (bnd)          ovf_sticky <= 1'b1;
      else if (ovf_clr) ovf_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tt_um_prog_counter.sv
// Directed + random check of tt_um_prog_counter (WIDTH=4, MODULO=10).
module tb_tt_um_prog_counter;
  localparam int WIDTH   = 4;
  localparam int MODULO  = 10;
  localparam int PRESC_W = 4;
  localparam int MAXV    = MODULO - 1;

  logic               clk = 1'b0;
  logic               reset, en, clear, load, dir, sat, ovf_clr;
  logic [WIDTH-1:0]   load_val, cmp_val;
  logic [PRESC_W-1:0] presc_div;
  logic [WIDTH-1:0]   count;
  logic               tc, cmp_match, ovf_sticky;

  int vecs = 0;
  int miscmp = 0;

  // reference state
  int m_count, m_presc, m_tc, m_cmp, m_ovf;

  always #5 clk = ~clk;

  tt_um_prog_counter #(.WIDTH(WIDTH), .MODULO(MODULO), .PRESC_W(PRESC_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .clear      (clear),
    .load       (load),
    .load_val   (load_val),
    .dir        (dir),
    .sat        (sat),
    .presc_div  (presc_div),
    .cmp_val    (cmp_val),
    .ovf_clr    (ovf_clr),
    .count      (count),
    .tc         (tc),
    .cmp_match  (cmp_match),
    .ovf_sticky (ovf_sticky)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    vecs++;
    if (obs !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural reference: one clock edge worth of the counter's rules
  task automatic model_edge();
    bit tick, bnd;
    tick = 0;
    bnd  = 0;
    if (reset) begin
      m_count = 0; m_presc = 0; m_tc = 0; m_ovf = 0;
      m_cmp = (cmp_val == 0);
      return;
    end
    if (clear) begin
      m_count = 0; m_presc = 0;
    end else if (load) begin
      m_count = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
      m_presc = 0;
    end else begin
      if (en) begin
        if (m_presc >= int'(presc_div)) begin tick = 1; m_presc = 0; end
        else m_presc++;
      end
      if (tick) begin
        if (dir) begin
          bnd = (m_count == MAXV);
          if (bnd && sat) m_count = MAXV;
          else m_count = (m_count + 1) % MODULO;
        end else begin
          bnd = (m_count == 0);
          if (bnd && sat) m_count = 0;
          else m_count = (m_count + MODULO - 1) % MODULO;
        end
      end
    end
    m_tc = bnd;
    if (bnd) m_ovf = 1;
    else if (ovf_clr) m_ovf = 0;
    m_cmp = (m_count == int'(cmp_val));
  endtask

  // One clock: advance model at the edge, compare 1 time unit later
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("count", int'(count), m_count);
    chk("tc", int'(tc), m_tc);
    chk("cmp_match", int'(cmp_match), m_cmp);
    chk("ovf_sticky", int'(ovf_sticky), m_ovf);
  endtask

  initial begin
    reset = 1; en = 0; clear = 0; load = 0; load_val = '0; dir = 1; sat = 0;
    presc_div = '0; cmp_val = 4'd5; ovf_clr = 0;
    m_count = 0; m_presc = 0; m_tc = 0; m_cmp = 0; m_ovf = 0;
    cyc(); cyc();
    chk("rst_count", int'(count), 0);
    chk("rst_tc", int'(tc), 0);
    chk("rst_cmp", int'(cmp_match), 0);
    chk("rst_ovf", int'(ovf_sticky), 0);

    // up, wrap, every cycle
    reset = 0; en = 1;
    for (int i = 0; i < 11; i++) begin
      cyc();
      chk("up_seq", int'(count), (i + 1) % MODULO);
      chk("up_tc", int'(tc), (i == 9) ? 1 : 0);
    end
    chk("up_ovf", int'(ovf_sticky), 1);

    // down from 0 with wrap, then saturate at 0
    clear = 1; cyc(); clear = 0;
    dir = 0;
    for (int i = 0; i < 12; i++) cyc();
    clear = 1; cyc(); clear = 0;
    sat = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("sat_hold", int'(count), 0);
      chk("sat_tc", int'(tc), 1);
    end
    sat = 0; dir = 1;

    // prescaler /3 with an en gap mid-period
    presc_div = 4'd2; clear = 1; cyc(); clear = 0;
    for (int i = 0; i < 4; i++) cyc();
    en = 0;
    for (int i = 0; i < 5; i++) cyc();
    en = 1;
    for (int i = 0; i < 8; i++) cyc();
    presc_div = '0;

    // load clamp, load+clear, reset+load
    load = 1; load_val = 4'd13; cyc();
    chk("load_clamp", int'(count), MAXV);
    clear = 1; cyc();
    chk("load_clear", int'(count), 0);
    clear = 0; reset = 1; cmp_val = 4'd0; cyc();
    chk("rst_load_count", int'(count), 0);
    chk("rst_load_cmp", int'(cmp_match), 1);
    reset = 0; load = 0; cmp_val = 4'd5;

    // ovf_clr alone, then against a boundary step
    en = 1; cyc(); en = 0;
    for (int i = 0; i < 9; i++) begin en = 1; cyc(); end
    en = 0; ovf_clr = 1; cyc();
    chk("ovf_clr_alone", int'(ovf_sticky), 0);
    load = 1; load_val = 4'd9; ovf_clr = 0; cyc(); load = 0;
    en = 1; ovf_clr = 1; cyc();
    chk("ovf_set_wins", int'(ovf_sticky), 1);
    chk("ovf_tc", int'(tc), 1);
    en = 0; cyc();
    chk("ovf_cleared", int'(ovf_sticky), 0);
    ovf_clr = 0;

    // random
    for (int i = 0; i < 2000; i++) begin
      reset     = ($urandom_range(0, 63) == 0);
      clear     = ($urandom_range(0, 15) == 0);
      load      = ($urandom_range(0, 15) == 0);
      load_val  = WIDTH'($urandom_range(0, 15));
      en        = ($urandom_range(0, 3) != 0);
      dir       = ($urandom_range(0, 4) != 0) ? ($urandom_range(0, 1) == 1) : 1'b0;
      sat       = ($urandom_range(0, 3) == 0);
      presc_div = PRESC_W'($urandom_range(0, 3));
      cmp_val   = ($urandom_range(0, 7) == 0) ? WIDTH'($urandom_range(0, 15))
                                              : cmp_val;
      ovf_clr   = ($urandom_range(0, 7) == 0);
      cyc();
      if (count > WIDTH'(MAXV)) chk("count_range", int'(count), MAXV);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule
